fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch sequencer that feeds instruction words to the opcode decoder and consumes the decoder's 2-bit branch code to choose the next PC. It holds the PC, runs a variable-latency request/response handshake with instruction memory, and presents one instruction at a time on a valid/ready interface. It resolves the sequential, PC-relative, register and halt cases, including condition-code evaluation for PC-relative branches.

Parameters:
PC_W, 16, PC and instruction-address width; PC arithmetic is modulo 2^PC_W.
RESET_PC, 16'h0000, PC loaded on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  instruction-memory request; held high until imem_valid
imem_addr  out  PC_W  fetch address; equals pc while imem_req=1
imem_valid  in  1  response strobe; may coincide with the first imem_req cycle
imem_rdata  in  16  instruction word; sampled only when imem_valid=1 in REQ
instr_valid  out  1  instr holds a fetched instruction
instr  out  16  instruction word to the decoder; opcode is [15:12]
instr_ready  in  1  decoder and datapath accept instr this cycle
branch  in  2  from decoder: 00 = PC+2, 01 = PC+2+offset, 10 = register, 11 = halt
rs_data  in  PC_W  register target for branch=10
flags  in  3  {Z,V,N} condition flags, sampled at the accept cycle
pc  out  PC_W  address of the current or in-flight instruction
pc_plus2  out  PC_W  pc+2, used by the datapath for PCS
halted  out  1  sticky halt indicator

Behaviour:
- States: REQ, ISSUE, HALT.
- Reset: state=REQ, pc=RESET_PC, instr=16'h0000, instr_valid=0, halted=0. imem_req is 0 in the reset cycle and 1 from the first post-reset cycle.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_valid: instr<=imem_rdata, go to ISSUE.
  - Zero-wait memory: a request in cycle N gives instr_valid in cycle N+1.
- ISSUE:
  - instr_valid=1; instr and pc are held stable until the accept cycle.
  - Accept cycle is instr_valid & instr_ready. branch, rs_data and flags are sampled only in this cycle.
- Next-PC on accept:
  - 00: pc+2.
  - 01: condition true -> pc+2+(sext(instr[8:0])<<1); false -> pc+2.
  - 10: {rs_data[PC_W-1:1],1'b0}; bit 0 is forced to 0.
  - After 00/01/10: go to REQ.
  - 11: pc unchanged, halted<=1, go to HALT.
- Conditions, ccc=instr[11:9]:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | (Z=0 & N=0)
  - 101 LTE: N=1 | Z=1
  - 110 OVFL: V=1
  - 111 always true
- HALT: imem_req=0, instr_valid=0. Sticky until rst; instr_ready and imem_valid are ignored.
- imem_valid outside REQ is ignored. Only one request is ever outstanding.
- pc_plus2 = pc+2 combinationally. All adds wrap: 16'hFFFE + 2 = 16'h0000.
- Minimum throughput is one instruction per 2 cycles. Each instr_ready-low cycle in ISSUE adds one cycle.
- Reset mid-operation: rst wins over every other event and abandons any outstanding request. Instruction memory is required to drop its pending response on rst.
- Simultaneous events:
  - imem_valid in the same cycle as rst: ignored.
  - Accept in the same cycle as rst: ignored; pc=RESET_PC.

Decomposition:
- Package fetch_pkg:
  - state encoding (REQ, ISSUE, HALT)
  - branch codes BR_SEQ=2'b00, BR_IMM=2'b01, BR_REG=2'b10, BR_HALT=2'b11
  - ccc codes
  - field positions: OPC_MSB/LSB, CCC_MSB/LSB, IMM9 width
- One combinational sub-module, branch_cond, maps ccc and flags to a taken bit.
- The FSM, PC register and next-PC mux live in fetch_unit.

Test Plan:
- Reset and zero-wait fetch:
  - Stimulus: rst for 2 cycles, imem_valid tied high, instr_ready high, branch=00.
  - Required: imem_addr sequence 0000, 0002, 0004; instr_valid every other cycle; pc_plus2 = pc+2.
- Memory wait states and decoder stall:
  - Stimulus: imem_valid 3 cycles after req; instr_ready low 2 cycles.
  - Required: imem_req held 4 cycles; instr and pc stable while stalled; no second request before accept.
- Conditional branch:
  - Stimulus: pc=0010, instr=16'hC3FE (ccc=001, imm9=-2), branch=01.
  - Required: Z=1 gives next fetch at 000E; Z=0 gives next fetch at 0012.
- Register branch and halt:
  - Stimulus: branch=10 with rs_data=1235.
  - Required: next fetch at 1234.
  - Stimulus: then branch=11.
  - Required: halted=1, imem_req=0, pc=1234, unchanged for 10 cycles despite imem_valid/instr_ready.
- Wrap:
  - Stimulus: pc=FFFE, branch=00.
  - Required: next imem_addr=0000.
  - Stimulus: pc=FFFC, branch=01, ccc=111, imm9=+1.
  - Required: next fetch at 0000.
- Reset mid-operation:
  - Stimulus: rst asserted in REQ while waiting for memory, and separately in the same cycle as an accept with branch=01.
  - Required: next cycle pc=RESET_PC, instr_valid=0, halted=0; fetch restarts at 0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch sequencer: FSM states, decoder
// branch codes, condition codes and instruction field positions.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam logic [1:0] BR_SEQ  = 2'b00;
    localparam logic [1:0] BR_IMM  = 2'b01;
    localparam logic [1:0] BR_REG  = 2'b10;
    localparam logic [1:0] BR_HALT = 2'b11;

    typedef enum logic [2:0] {
        CC_NE   = 3'b000,
        CC_EQ   = 3'b001,
        CC_GT   = 3'b010,
        CC_LT   = 3'b011,
        CC_GTE  = 3'b100,
        CC_LTE  = 3'b101,
        CC_OVFL = 3'b110,
        CC_AL   = 3'b111
    } ccc_e;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int CCC_MSB = 11;
    localparam int CCC_LSB = 9;
    localparam int IMM9_W  = 9;

endpackage

// File: rtl/fetch_unit_branch_cond.sv
// Condition-code evaluation for PC-relative branches.
// flags are packed {Z,V,N}.
module branch_cond
    import fetch_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z, v, n;

    assign z = flags[2];
    assign v = flags[1];
    assign n = flags[0];

    always_comb begin
        taken = 1'b0;
        unique case (ccc_e'(ccc))
            CC_NE:   taken = ~z;
            CC_EQ:   taken = z;
            CC_GT:   taken = ~z & ~n;
            CC_LT:   taken = n;
            CC_GTE:  taken = z | (~z & ~n);
            CC_LTE:  taken = n | z;
            CC_OVFL: taken = v;
            CC_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: PC register, memory request handshake,
// valid/ready issue to the decoder and next-PC selection.
//
// state    | meaning
// ST_REQ   | request outstanding at pc, waiting for imem_valid
// ST_ISSUE | instr valid, waiting for the decoder to accept it
// ST_HALT  | halt accepted; idle until reset
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_rdata,
    output logic            instr_valid,
    output logic [15:0]     instr,
    input  logic            instr_ready,
    input  logic [1:0]      branch,
    input  logic [PC_W-1:0] rs_data,
    input  logic [2:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus2,
    output logic            halted
);

    fetch_state_e    state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     instr_nxt;
    logic            halted_nxt;
    logic            cond_taken;
    logic [PC_W-1:0] imm_off;
    logic [PC_W-1:0] pc_rel;
    logic [PC_W-1:0] pc_reg;

    branch_cond u_branch_cond (
        .ccc   (instr[CCC_MSB:CCC_LSB]),
        .flags (flags),
        .taken (cond_taken)
    );

    assign pc_plus2  = pc + PC_W'(2);
    assign imem_addr = pc;

    // Word offset: sign-extended imm9 scaled to bytes.
    assign imm_off = {{(PC_W-IMM9_W){instr[IMM9_W-1]}}, instr[IMM9_W-1:0]} << 1;
    assign pc_rel  = pc_plus2 + imm_off;
    assign pc_reg  = rs_data & ~PC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_REQ;
            pc     <= RESET_PC;
            instr  <= 16'h0000;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            instr  <= instr_nxt;
            halted <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instr_nxt   = instr;
        halted_nxt  = halted;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state)
            ST_REQ: begin
                imem_req = ~rst;
                if (imem_valid) begin
                    instr_nxt = imem_rdata;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_nxt = ST_REQ;
                    unique case (branch)
                        BR_SEQ:  pc_nxt = pc_plus2;
                        BR_IMM:  pc_nxt = cond_taken ? pc_rel : pc_plus2;
                        BR_REG:  pc_nxt = pc_reg;
                        BR_HALT: begin
                            halted_nxt = 1'b1;
                            state_nxt  = ST_HALT;
                        end
                        default: pc_nxt = pc_plus2;
                    endcase
                end
            end
            ST_HALT: ;
            default: state_nxt = ST_REQ;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench plays instruction memory and
// decoder, and predicts every fetch address from a transaction-level model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [1:0]  branch;
    logic [15:0] rs_data;
    logic [2:0]  flags;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        halted;

    int total = 0;
    int bad   = 0;
    int m_pc  = 0;

    fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .branch      (branch),
        .rs_data     (rs_data),
        .flags       (flags),
        .pc          (pc),
        .pc_plus2    (pc_plus2),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_true(input int ccc, input bit z, input bit v, input bit n);
        case (ccc)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || (!z && !n);
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Expected next PC after an accepted instruction, with 16-bit wrap.
    function automatic int ref_next(input int cur, input logic [15:0] word, input int br,
                                    input int rs, input logic [2:0] fl);
        int imm;
        imm = int'(word[8:0]);
        if (imm >= 256) imm = imm - 512;
        case (br)
            0: return (cur + 2) % 65536;
            1: begin
                if (cond_true(int'(word[11:9]), fl[2], fl[1], fl[0]))
                    return (cur + 2 + 2 * imm + 65536) % 65536;
                return (cur + 2) % 65536;
            end
            2: return rs - (rs % 2);
            default: return cur;
        endcase
    endfunction

    // Entered at a negedge with the DUT expected in REQ at m_pc; leaves it in ISSUE.
    task automatic fetch_to_issue(input int wt, input logic [15:0] word);
        #1;
        chk("req_on", 32'(imem_req), 32'd1);
        chk("req_addr", 32'(imem_addr), 32'(m_pc));
        chk("req_pc_plus2", 32'(pc_plus2), 32'((m_pc + 2) % 65536));
        chk("req_no_valid", 32'(instr_valid), 32'd0);
        imem_valid = 1'b0;
        for (int i = 0; i < wt; i++) begin
            @(negedge clk);
            chk("wait_req_held", 32'(imem_req), 32'd1);
            chk("wait_addr_held", 32'(imem_addr), 32'(m_pc));
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        chk("issue_valid", 32'(instr_valid), 32'd1);
        chk("issue_instr", 32'(instr), 32'(word));
        chk("issue_no_req", 32'(imem_req), 32'd0);
        chk("issue_pc", 32'(pc), 32'(m_pc));
    endtask

    task automatic accept(input int stl, input logic [15:0] word, input logic [1:0] br,
                          input logic [15:0] rs, input logic [2:0] fl);
        for (int i = 0; i < stl; i++) begin
            instr_ready = 1'b0;
            imem_valid  = 1'($urandom);
            branch      = 2'($urandom);
            @(negedge clk);
            chk("stall_instr", 32'(instr), 32'(word));
            chk("stall_pc", 32'(pc), 32'(m_pc));
            chk("stall_no_req", 32'(imem_req), 32'd0);
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        imem_valid  = 1'b0;
        instr_ready = 1'b1;
        branch      = br;
        rs_data     = rs;
        flags       = fl;
        @(negedge clk);
        instr_ready = 1'b0;
        branch      = 2'($urandom);
        flags       = 3'($urandom);
        m_pc = ref_next(m_pc, word, int'(br), int'(rs), fl);
    endtask

    task automatic do_fetch(input int wt, input int stl, input logic [15:0] word,
                            input logic [1:0] br, input logic [15:0] rs, input logic [2:0] fl);
        fetch_to_issue(wt, word);
        accept(stl, word, br, rs, fl);
    endtask

    initial begin
        logic [15:0] w;
        logic [1:0]  b;

        rst = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'hABCD;
        instr_ready = 1'b1;
        branch = 2'b00;
        rs_data = 16'h0000;
        flags = 3'b000;
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_instr", 32'(instr), 32'h0000);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        instr_ready = 1'b0;
        m_pc = 0;

        // zero-wait sequential fetches: 0000, 0002, 0004
        for (int i = 0; i < 3; i++) do_fetch(0, 0, 16'(16'h1000 + i), 2'b00, 16'h0, 3'b0);
        chk("seq_pc", 32'(pc), 32'h0006);

        // memory wait states and decoder stall
        do_fetch(3, 2, 16'h2345, 2'b00, 16'h0, 3'b0);

        // conditional branch at 0010, C3FE (EQ, imm9=-2)
        do_fetch(0, 0, 16'h0000, 2'b10, 16'h0010, 3'b0);
        do_fetch(1, 0, 16'hC3FE, 2'b01, 16'h0, 3'b100);
        chk("cond_taken_pc", 32'(m_pc), 32'h000E);
        do_fetch(0, 0, 16'h0000, 2'b10, 16'h0010, 3'b0);
        do_fetch(0, 1, 16'hC3FE, 2'b01, 16'h0, 3'b011);
        chk("cond_not_taken_pc", 32'(m_pc), 32'h0012);

        // wrap cases
        do_fetch(0, 0, 16'h0000, 2'b10, 16'hFFFE, 3'b0);
        do_fetch(0, 0, 16'h0000, 2'b00, 16'h0, 3'b0);
        do_fetch(0, 0, 16'h0000, 2'b10, 16'hFFFC, 3'b0);
        do_fetch(0, 0, 16'hCE01, 2'b01, 16'h0, 3'b000);
        chk("wrap_model_pc", 32'(m_pc), 32'h0000);

        // randomized fetch stream against the model
        for (int i = 0; i < 200; i++) begin
            w = 16'($urandom);
            b = 2'($urandom_range(0, 2));
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), w, b,
                     16'($urandom), 3'($urandom));
        end
        do_fetch(0, 0, 16'h0000, 2'b10, 16'h4444, 3'b0);

        // reset while waiting for memory, with a coincident response
        #1;
        imem_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("pre_rst_req", 32'(imem_req), 32'd1);
        end
        rst = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'h7777;
        @(negedge clk);
        chk("rst_req_pc", 32'(pc), 32'h0000);
        chk("rst_req_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        imem_valid = 1'b0;
        m_pc = 0;
        do_fetch(0, 0, 16'h0000, 2'b10, 16'h0200, 3'b0);

        // reset coincident with an accept of a taken branch
        fetch_to_issue(0, 16'hCE10);
        instr_ready = 1'b1;
        branch = 2'b01;
        flags = 3'b000;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_acc_pc", 32'(pc), 32'h0000);
        chk("rst_acc_valid", 32'(instr_valid), 32'd0);
        chk("rst_acc_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        instr_ready = 1'b0;
        m_pc = 0;
        do_fetch(0, 0, 16'h0000, 2'b00, 16'h0, 3'b0);

        // register branch then halt
        do_fetch(0, 0, 16'h0000, 2'b10, 16'h1235, 3'b0);
        chk("reg_branch_pc", 32'(m_pc), 32'h1234);
        do_fetch(2, 1, 16'hF000, 2'b11, 16'h5555, 3'b111);
        for (int i = 0; i < 10; i++) begin
            imem_valid  = 1'($urandom);
            imem_rdata  = 16'($urandom);
            instr_ready = 1'($urandom);
            branch      = 2'($urandom);
            @(negedge clk);
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_no_req", 32'(imem_req), 32'd0);
            chk("halt_no_valid", 32'(instr_valid), 32'd0);
            chk("halt_pc", 32'(pc), 32'h1234);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
